// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
// Module      : video_pkg
// Description : Shared video types and constants: RGB565 pixel layout, the
//               per-axis raster timing description and the fixed scanout
//               pipeline latency.
// Revision    : 1.0 - initial release
// ============================================================================
package video_pkg;

    // Counter stage to output pins, in clocks.
    localparam int PIPE_LAT = 3;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    // One axis of raster timing (horizontal in clocks, vertical in lines).
    typedef struct packed {
        logic [15:0] fp;
        logic [15:0] sync;
        logic [15:0] bp;
        logic [15:0] active;
    } video_timing_t;

    function automatic int timing_total(input video_timing_t t);
        return int'(t.active) + int'(t.fp) + int'(t.sync) + int'(t.bp);
    endfunction

endpackage
`default_nettype wire

// File: rtl/framebuffer_scanout_if.sv
`default_nettype none
// ============================================================================
// Module      : framebuffer_scanout_if
// Description : Framebuffer read port plus front/back buffer swap handshake.
//               master : scanout side (drives address, buffer select, ack)
//               slave  : memory/producer side (drives read data, swap request)
// Ports       : fb_rd_addr, fb_rd_data (1-clk read latency), fb_sel,
//               swap_req (level), swap_ack (1-clk pulse)
// Revision    : 1.0 - initial release
// ============================================================================
interface framebuffer_scanout_if #(
    parameter int ADDR_BITS = 14,
    parameter int DATA_BITS = 16
);
    logic [ADDR_BITS-1:0] fb_rd_addr;
    logic [DATA_BITS-1:0] fb_rd_data;
    logic                 fb_sel;
    logic                 swap_req;
    logic                 swap_ack;

    modport master (
        output fb_rd_addr,
        input  fb_rd_data,
        output fb_sel,
        input  swap_req,
        output swap_ack
    );

    modport slave (
        input  fb_rd_addr,
        output fb_rd_data,
        input  fb_sel,
        output swap_req,
        input  swap_ack
    );
endinterface
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : video_timing_gen
// Description : Raster counters and undelayed (counter-stage) timing strobes.
// Ports       : clk, rst (sync, active high)
//               h_cnt, v_cnt      raster position
//               h_wrap, v_wrap    last clock of line / of frame
//               de_raw            position inside the active area
//               hsync_raw/vsync_raw  sync window, logical active-high
//               vblank            v_cnt >= active lines
//               frame_start       pulse at (0,0), suppressed during reset
// Revision    : 1.0 - initial release
// ============================================================================
module video_timing_gen
    import video_pkg::*;
#(
    parameter video_timing_t H_TIMING = '{fp: 16'd4, sync: 16'd8, bp: 16'd4, active: 16'd100},
    parameter video_timing_t V_TIMING = '{fp: 16'd2, sync: 16'd2, bp: 16'd2, active: 16'd100},
    localparam int H_TOTAL = timing_total(H_TIMING),
    localparam int V_TOTAL = timing_total(V_TIMING),
    localparam int H_BITS  = $clog2(H_TOTAL),
    localparam int V_BITS  = $clog2(V_TOTAL)
) (
    input  logic              clk,
    input  logic              rst,
    output logic [H_BITS-1:0] h_cnt,
    output logic [V_BITS-1:0] v_cnt,
    output logic              h_wrap,
    output logic              v_wrap,
    output logic              de_raw,
    output logic              hsync_raw,
    output logic              vsync_raw,
    output logic              vblank,
    output logic              frame_start
);
    localparam logic [H_BITS-1:0] H_LAST   = H_BITS'(H_TOTAL - 1);
    localparam logic [V_BITS-1:0] V_LAST   = V_BITS'(V_TOTAL - 1);
    localparam logic [H_BITS-1:0] H_ACT    = H_BITS'(int'(H_TIMING.active));
    localparam logic [V_BITS-1:0] V_ACT    = V_BITS'(int'(V_TIMING.active));
    localparam logic [H_BITS-1:0] HS_FIRST = H_BITS'(int'(H_TIMING.active) + int'(H_TIMING.fp));
    localparam logic [H_BITS-1:0] HS_LAST  = H_BITS'(int'(H_TIMING.active) + int'(H_TIMING.fp)
                                                     + int'(H_TIMING.sync) - 1);
    localparam logic [V_BITS-1:0] VS_FIRST = V_BITS'(int'(V_TIMING.active) + int'(V_TIMING.fp));
    localparam logic [V_BITS-1:0] VS_LAST  = V_BITS'(int'(V_TIMING.active) + int'(V_TIMING.fp)
                                                     + int'(V_TIMING.sync) - 1);

    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = h_wrap && (v_cnt == V_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_wrap) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + V_BITS'(1);
        end else begin
            h_cnt <= h_cnt + H_BITS'(1);
        end
    end

    assign de_raw      = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hsync_raw   = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
    assign vsync_raw   = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
    assign vblank      = (v_cnt >= V_ACT);
    // Counters sit at (0,0) throughout reset; only report the frame once running.
    assign frame_start = !rst && (h_cnt == '0) && (v_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/framebuffer_scanout.sv
`default_nettype none
// ============================================================================
// Module      : framebuffer_scanout
// Description : Display-side framebuffer reader. Generates raster timing,
//               fetches one word per active pixel (row_base + column, no
//               multiplier) and presents RGB565 pixels 3 clocks after the
//               counter position. Swaps front/back buffer on request at the
//               first vertical-blank line only.
// Option      : PIXEL_DOUBLE_EN - each framebuffer word shown as a 2x2 block
//               (active area doubled on both axes, latency unchanged).
// Ports       : clk, rst (sync, active high)
//               fb      framebuffer_scanout_if.master (read port + swap)
//               pix_r/pix_g/pix_b  pixel colour, zero outside active area
//               hsync, vsync       sync, polarity per SYNC_ACTIVE_HIGH
//               de                 active video, aligned with pixels
//               vblank, frame_start  counter-stage (undelayed) strobes
// Revision    : 1.0 - initial release
// ============================================================================
module framebuffer_scanout
    import video_pkg::*;
#(
    parameter int DISPLAY_WIDTH         = 100,
    parameter int DISPLAY_HEIGHT        = 100,
    parameter int H_FP                  = 4,
    parameter int H_SYNC                = 8,
    parameter int H_BP                  = 4,
    parameter int V_FP                  = 2,
    parameter int V_SYNC                = 2,
    parameter int V_BP                  = 2,
    parameter int SYNC_ACTIVE_HIGH      = 0,
    parameter int FRAMEBUFFER_DATA_BITS = 16,
    parameter int FRAMEBUFFER_ADDR_BITS = $clog2(DISPLAY_WIDTH * DISPLAY_HEIGHT)
) (
    input  logic                         clk,
    input  logic                         rst,
    framebuffer_scanout_if.master        fb,
    output logic [4:0]                   pix_r,
    output logic [5:0]                   pix_g,
    output logic [4:0]                   pix_b,
    output logic                         hsync,
    output logic                         vsync,
    output logic                         de,
    output logic                         vblank,
    output logic                         frame_start
);
`ifdef PIXEL_DOUBLE_EN
    localparam int SCALE = 2;
`else
    localparam int SCALE = 1;
`endif
    localparam int H_ACTIVE = SCALE * DISPLAY_WIDTH;
    localparam int V_ACTIVE = SCALE * DISPLAY_HEIGHT;

    localparam video_timing_t H_TIMING = '{fp: 16'(H_FP), sync: 16'(H_SYNC),
                                           bp: 16'(H_BP), active: 16'(H_ACTIVE)};
    localparam video_timing_t V_TIMING = '{fp: 16'(V_FP), sync: 16'(V_SYNC),
                                           bp: 16'(V_BP), active: 16'(V_ACTIVE)};
    localparam int H_BITS = $clog2(timing_total(H_TIMING));
    localparam int V_BITS = $clog2(timing_total(V_TIMING));
    localparam int AW     = FRAMEBUFFER_ADDR_BITS;

    localparam logic [V_BITS-1:0] V_SWAP    = V_BITS'(V_ACTIVE);
    localparam logic [AW-1:0]     ROW_PITCH = AW'(DISPLAY_WIDTH);

    logic [H_BITS-1:0] h_cnt;
    logic [V_BITS-1:0] v_cnt;
    logic              h_wrap;
    logic              v_wrap;
    logic              de_raw;
    logic              hsync_raw;
    logic              vsync_raw;

    video_timing_gen #(
        .H_TIMING (H_TIMING),
        .V_TIMING (V_TIMING)
    ) u_timing (
        .clk         (clk),
        .rst         (rst),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .h_wrap      (h_wrap),
        .v_wrap      (v_wrap),
        .de_raw      (de_raw),
        .hsync_raw   (hsync_raw),
        .vsync_raw   (vsync_raw),
        .vblank      (vblank),
        .frame_start (frame_start)
    );

    // ------------------------------------------------------------------
    // Addressing: row_base accumulates the row pitch at each line end
    // ------------------------------------------------------------------
    logic [AW-1:0] row_base;
    logic [AW-1:0] column;
    logic          row_step;

`ifdef PIXEL_DOUBLE_EN
    // Each word spans two clocks and two lines.
    assign column   = AW'(h_cnt >> 1);
    assign row_step = v_cnt[0];
`else
    assign column   = AW'(h_cnt);
    assign row_step = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst || v_wrap) begin
            row_base <= '0;
        end else if (h_wrap && !vblank && row_step) begin
            row_base <= row_base + ROW_PITCH;
        end
    end

    // ------------------------------------------------------------------
    // Pipeline: counter -> address reg -> memory data -> output reg.
    // Index 0 of each delay line is stage 1, index PIPE_LAT-1 drives pins.
    // ------------------------------------------------------------------
    logic [PIPE_LAT-1:0] de_pipe;
    logic [PIPE_LAT-1:0] hs_pipe;
    logic [PIPE_LAT-1:0] vs_pipe;
    rgb565_t             pix_word;
    rgb565_t             pix_q;

    // RGB565 occupies the top bits of the framebuffer word.
    assign pix_word = fb.fb_rd_data[FRAMEBUFFER_DATA_BITS-1 -: $bits(rgb565_t)];

    always_ff @(posedge clk) begin
        if (rst) begin
            de_pipe       <= '0;
            hs_pipe       <= '0;
            vs_pipe       <= '0;
            pix_q         <= '0;
            fb.fb_rd_addr <= '0;
        end else begin
            de_pipe <= {de_pipe[PIPE_LAT-2:0], de_raw};
            hs_pipe <= {hs_pipe[PIPE_LAT-2:0], hsync_raw};
            vs_pipe <= {vs_pipe[PIPE_LAT-2:0], vsync_raw};
            // Address holds outside the active area.
            if (de_raw) begin
                fb.fb_rd_addr <= row_base + column;
            end
            // Memory data for this pixel is valid now (stage 2).
            pix_q <= de_pipe[PIPE_LAT-2] ? pix_word : '0;
        end
    end

    assign de    = de_pipe[PIPE_LAT-1];
    assign hsync = (SYNC_ACTIVE_HIGH != 0) ? hs_pipe[PIPE_LAT-1] : ~hs_pipe[PIPE_LAT-1];
    assign vsync = (SYNC_ACTIVE_HIGH != 0) ? vs_pipe[PIPE_LAT-1] : ~vs_pipe[PIPE_LAT-1];
    assign pix_r = pix_q.r;
    assign pix_g = pix_q.g;
    assign pix_b = pix_q.b;

    // ------------------------------------------------------------------
    // Buffer swap: sampled only on the first clock of the first blank line,
    // so a late request waits a full frame. A held request swaps every frame.
    // ------------------------------------------------------------------
    assign fb.swap_ack = !rst && fb.swap_req && (v_cnt == V_SWAP) && (h_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            fb.fb_sel <= 1'b0;
        end else if (fb.swap_ack) begin
            fb.fb_sel <= ~fb.fb_sel;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_framebuffer_scanout.sv
`default_nettype none
// ============================================================================
// Module      : tb_framebuffer_scanout
// Description : Self-checking bench for framebuffer_scanout. A raster model
//               derives every expected output from the cycle index since the
//               last reset; memory returns addr + 0x100 one clock later.
//               Builds with or without PIXEL_DOUBLE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_framebuffer_scanout;

    localparam int W   = 4;
    localparam int H   = 3;
    localparam int HFP = 1, HSY = 2, HBP = 1;
    localparam int VFP = 1, VSY = 1, VBP = 1;
    localparam int SAH = 1;
    localparam int AB  = $clog2(W * H);
    localparam int LAT = 3;
`ifdef PIXEL_DOUBLE_EN
    localparam int S = 2;
`else
    localparam int S = 1;
`endif
    localparam int HA    = W * S;
    localparam int VA    = H * S;
    localparam int HT    = HA + HFP + HSY + HBP;
    localparam int VT    = VA + VFP + VSY + VBP;
    localparam int FRAME = HT * VT;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] pix_r;
    logic [5:0] pix_g;
    logic [4:0] pix_b;
    logic       hsync, vsync, de, vblank, frame_start;

    framebuffer_scanout_if #(.ADDR_BITS(AB), .DATA_BITS(16)) fb_bus ();

    framebuffer_scanout #(
        .DISPLAY_WIDTH         (W),
        .DISPLAY_HEIGHT        (H),
        .H_FP                  (HFP),
        .H_SYNC                (HSY),
        .H_BP                  (HBP),
        .V_FP                  (VFP),
        .V_SYNC                (VSY),
        .V_BP                  (VBP),
        .SYNC_ACTIVE_HIGH      (SAH),
        .FRAMEBUFFER_DATA_BITS (16),
        .FRAMEBUFFER_ADDR_BITS (AB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fb          (fb_bus),
        .pix_r       (pix_r),
        .pix_g       (pix_g),
        .pix_b       (pix_b),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .vblank      (vblank),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory, one clock latency.
    always @(posedge clk) fb_bus.fb_rd_data <= 16'(fb_bus.fb_rd_addr) + 16'h0100;

    // Model state
    int n         = 0;   // clocks since the last reset edge
    bit sel_m     = 1'b0;
    int last_addr = 0;
    int errors    = 0;
    int checks    = 0;
    int acks      = 0;
    int fs_seen   = 0;

    function automatic int addr_of(input int h, input int v);
        return (v / S) * W + h / S;
    endfunction

    function automatic bit in_active(input int h, input int v);
        return (h < HA) && (v < VA);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at n=%0d: got %0h expected %0h", tag, n, got, exp);
        end
    endtask

    task automatic check_outputs();
        int h, v, hd, vd, pix_e;
        bit de_e, hs_e, vs_e;
        if (!rst) begin
            h = n % HT;
            v = (n / HT) % VT;
            if (frame_start) fs_seen++;
            if (fb_bus.swap_ack) acks++;
            check_eq("frame_start", 32'(frame_start), 32'(h == 0 && v == 0));
            check_eq("vblank", 32'(vblank), 32'(v >= VA));
            check_eq("swap_ack", 32'(fb_bus.swap_ack), 32'(h == 0 && v == VA && fb_bus.swap_req));
            check_eq("fb_sel", 32'(fb_bus.fb_sel), 32'(sel_m));
            check_eq("fb_rd_addr", 32'(fb_bus.fb_rd_addr), 32'(last_addr));
            de_e  = 1'b0;
            hs_e  = 1'b0;
            vs_e  = 1'b0;
            pix_e = 0;
            if (n >= LAT) begin
                hd   = (n - LAT) % HT;
                vd   = ((n - LAT) / HT) % VT;
                de_e = in_active(hd, vd);
                hs_e = (hd >= HA + HFP) && (hd < HA + HFP + HSY);
                vs_e = (vd >= VA + VFP) && (vd < VA + VFP + VSY);
                if (de_e) pix_e = addr_of(hd, vd) + 'h100;
            end
            check_eq("de", 32'(de), 32'(de_e));
            check_eq("hsync", 32'(hsync), 32'((SAH != 0) ? hs_e : !hs_e));
            check_eq("vsync", 32'(vsync), 32'((SAH != 0) ? vs_e : !vs_e));
            check_eq("pixel", 32'({pix_r, pix_g, pix_b}), 32'(pix_e));
        end
    endtask

    // One clock: advance the model over the edge, drive the next inputs,
    // then compare on the falling edge.
    task automatic cycle(input logic r, input logic q);
        int h, v;
        @(posedge clk);
        if (rst) begin
            n         = 0;
            sel_m     = 1'b0;
            last_addr = 0;
        end else begin
            h = n % HT;
            v = (n / HT) % VT;
            if (h == 0 && v == VA && fb_bus.swap_req) sel_m = ~sel_m;
            if (in_active(h, v)) last_addr = addr_of(h, v);
            n++;
        end
        #1;
        rst             = r;
        fb_bus.swap_req = q;
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        int a0;
        logic r, q;
        fb_bus.swap_req = 1'b0;
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);

        // Two idle frames: timing and data path
        fs_seen = 0;
        repeat (2 * FRAME) cycle(1'b0, 1'b0);
        check_eq("frame_start_count", 32'(fs_seen), 32'd2);

        // Single swap requested mid-line 1, dropped after the ack
        while (((n + 1) % FRAME) != HT + 3) cycle(1'b0, 1'b0);
        a0 = acks;
        while ((n % FRAME) != VA * HT) cycle(1'b0, 1'b1);
        repeat (FRAME) cycle(1'b0, 1'b0);
        check_eq("single_swap_acks", 32'(acks - a0), 32'd1);
        check_eq("sel_after_swap", 32'(fb_bus.fb_sel), 32'd1);

        // Reset for one clock at (v=1, h=2)
        while (((n + 1) % FRAME) != HT + 2) cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        check_eq("post_reset_frame_start", 32'(frame_start), 32'd1);
        check_eq("post_reset_sel", 32'(fb_bus.fb_sel), 32'd0);
        repeat (FRAME) cycle(1'b0, 1'b0);

        // Request held for three frames
        a0 = acks;
        repeat (3 * FRAME) cycle(1'b0, 1'b1);
        check_eq("held_req_acks", 32'(acks - a0), 32'd3);
        check_eq("held_req_sel", 32'(fb_bus.fb_sel), 32'd1);
        repeat (FRAME) cycle(1'b0, 1'b0);

        // Random requests with occasional resets
        repeat (8 * FRAME) begin
            r = ($urandom_range(0, 149) == 0);
            q = ($urandom_range(0, 2) == 0);
            cycle(r, q);
        end
        repeat (FRAME) cycle(1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
